// File: rtl/lcd_pwr_seq.sv
// rtl/lcd_pwr_seq.sv - LCD panel power sequencer with frame-synchronous backlight PWM dimming
module lcd_pwr_seq #(
    parameter int T_PWR_CYC  = 1000,
    parameter int FRAMES_ON  = 2,
    parameter int FRAMES_OFF = 2,
    parameter int PWM_BITS   = 8
) (
    input  logic                clk_in,
    input  logic                sys_rst,
    input  logic                pwr_on_req,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                vsync_in,
    output logic                panel_pwr_en,
    output logic                timing_rst_n,
    output logic                lcd_bl_pwm,
    output logic                ready,
    output logic [2:0]          pwr_state
);

    localparam int TMR_W  = (T_PWR_CYC > 1) ? $clog2(T_PWR_CYC) : 1;
    localparam int FMAX   = (FRAMES_ON > FRAMES_OFF) ? FRAMES_ON : FRAMES_OFF;
    localparam int FCNT_W = $clog2(FMAX + 1);

    localparam logic [TMR_W-1:0]    TMR_LOAD = TMR_W'(T_PWR_CYC - 1);
    localparam logic [FCNT_W-1:0]   F_ON     = FCNT_W'(FRAMES_ON);
    localparam logic [FCNT_W-1:0]   F_OFF    = FCNT_W'(FRAMES_OFF);
    localparam logic [FCNT_W-1:0]   F_MAX    = FCNT_W'(FMAX);
    localparam logic [PWM_BITS-1:0] PWM_TOP  = {{(PWM_BITS-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_OFF        = 3'd0,
        S_PANEL_UP   = 3'd1,
        S_SCAN_UP    = 3'd2,
        S_BL_ON      = 3'd3,
        S_SCAN_DOWN  = 3'd4,
        S_PANEL_DOWN = 3'd5
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TMR_W-1:0]    timer;
    logic [FCNT_W-1:0]   frame_cnt;
    logic [FCNT_W-1:0]   frame_cnt_inc;
    logic                vsync_prev;
    logic                vs_rise;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_nxt;
    logic [PWM_BITS-1:0] cnt_pwm;
    logic [PWM_BITS-1:0] cnt_pwm_nxt;
    logic                tmr_load;

    always_comb begin
        vs_rise       = vsync_in & ~vsync_prev;
        frame_cnt_inc = (frame_cnt == F_MAX) ? frame_cnt : frame_cnt + 1'b1;
        state_nxt     = state;
        case (state)
            S_OFF:        if (pwr_on_req) state_nxt = S_PANEL_UP;
            S_PANEL_UP: begin
                if (!pwr_on_req)      state_nxt = S_PANEL_DOWN;
                else if (timer == '0) state_nxt = S_SCAN_UP;
            end
            S_SCAN_UP: begin
                if (!pwr_on_req)                          state_nxt = S_SCAN_DOWN;
                else if (vs_rise && frame_cnt_inc >= F_ON) state_nxt = S_BL_ON;
            end
            S_BL_ON:      if (!pwr_on_req) state_nxt = S_SCAN_DOWN;
            // Down sequence ignores pwr_on_req until it reaches OFF
            S_SCAN_DOWN:  if (vs_rise && frame_cnt_inc >= F_OFF) state_nxt = S_PANEL_DOWN;
            S_PANEL_DOWN: if (timer == '0) state_nxt = S_OFF;
            default:      state_nxt = S_OFF;
        endcase

        duty_nxt = duty;
        if ((state == S_SCAN_UP && state_nxt == S_BL_ON) || (state == S_BL_ON && vs_rise))
            duty_nxt = brightness;

        cnt_pwm_nxt = (cnt_pwm >= PWM_TOP) ? '0 : cnt_pwm + 1'b1;

        tmr_load = (state == S_OFF        && state_nxt == S_PANEL_UP)   ||
                   (state == S_PANEL_UP   && state_nxt == S_PANEL_DOWN) ||
                   (state == S_SCAN_DOWN  && state_nxt == S_PANEL_DOWN);
    end

    // Outputs are registered from the next state so they change on the same edge as the state
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= S_OFF;
            timer        <= '0;
            frame_cnt    <= '0;
            vsync_prev   <= 1'b1;
            duty         <= '0;
            cnt_pwm      <= '0;
            panel_pwr_en <= 1'b0;
            timing_rst_n <= 1'b0;
            lcd_bl_pwm   <= 1'b0;
            ready        <= 1'b0;
            pwr_state    <= 3'd0;
        end else begin
            state   <= state_nxt;
            duty    <= duty_nxt;
            cnt_pwm <= cnt_pwm_nxt;

            if (tmr_load)
                timer <= TMR_LOAD;
            else if ((state == S_PANEL_UP || state == S_PANEL_DOWN) && timer != '0)
                timer <= timer - 1'b1;

            if (state != state_nxt)
                frame_cnt <= '0;
            else if (vs_rise && (state == S_SCAN_UP || state == S_SCAN_DOWN))
                frame_cnt <= frame_cnt_inc;

            // Scan held in reset drives vsync high, so the edge detector must not see a rise on release
            vsync_prev <= timing_rst_n ? vsync_in : 1'b1;

            panel_pwr_en <= (state_nxt != S_OFF);
            timing_rst_n <= (state_nxt == S_SCAN_UP) || (state_nxt == S_BL_ON) ||
                            (state_nxt == S_SCAN_DOWN);
            ready        <= (state_nxt == S_BL_ON);
            lcd_bl_pwm   <= (state_nxt == S_BL_ON) && (cnt_pwm_nxt < duty_nxt);
            pwr_state    <= state_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_pwr_seq.sv
// tb/tb_lcd_pwr_seq.sv - self-checking bench for lcd_pwr_seq
module tb_lcd_pwr_seq;
    localparam int T    = 8;
    localparam int FON  = 2;
    localparam int FOFF = 1;
    localparam int PB   = 4;
    localparam int PER  = 15;
    localparam int NV   = 23;

    logic          clk_in = 1'b0;
    logic          sys_rst = 1'b1;
    logic          pwr_on_req = 1'b0;
    logic [PB-1:0] brightness = '0;
    logic          vsync_in = 1'b1;
    logic          panel_pwr_en;
    logic          timing_rst_n;
    logic          lcd_bl_pwm;
    logic          ready;
    logic [2:0]    pwr_state;
    logic [6:0]    dut_out;

    always #5 clk_in = ~clk_in;

    lcd_pwr_seq #(
        .T_PWR_CYC (T),
        .FRAMES_ON (FON),
        .FRAMES_OFF(FOFF),
        .PWM_BITS  (PB)
    ) dut (
        .clk_in      (clk_in),
        .sys_rst     (sys_rst),
        .pwr_on_req  (pwr_on_req),
        .brightness  (brightness),
        .vsync_in    (vsync_in),
        .panel_pwr_en(panel_pwr_en),
        .timing_rst_n(timing_rst_n),
        .lcd_bl_pwm  (lcd_bl_pwm),
        .ready       (ready),
        .pwr_state   (pwr_state)
    );

    assign dut_out = {panel_pwr_en, timing_rst_n, lcd_bl_pwm, ready, pwr_state};

    typedef struct {
        int            n;
        logic          req;
        logic [PB-1:0] bri;
        logic          vs;
        logic [2:0]    st;
        int            duty;
        int            hi;
    } vec_t;

    vec_t       vecs[NV];
    logic [6:0] sb_q[$];
    int         checks = 0;
    int         failures = 0;
    int         edge_cnt = 0;
    int         bl_hi = 0;

    function automatic vec_t mk(input int n, input logic req, input logic [PB-1:0] bri,
                                input logic vs, input logic [2:0] st, input int duty, input int hi);
        vec_t v;
        v.n = n; v.req = req; v.bri = bri; v.vs = vs; v.st = st; v.duty = duty; v.hi = hi;
        return v;
    endfunction

    // Expected {panel_pwr_en, timing_rst_n, lcd_bl_pwm, ready, pwr_state} for a state
    function automatic logic [6:0] expect_out(input logic [2:0] st, input int duty, input int phase);
        logic pe, trn, bl, rdy;
        pe  = (st != 3'd0);
        trn = (st inside {3'd2, 3'd3, 3'd4});
        rdy = (st == 3'd3);
        bl  = (st == 3'd3) && (phase < duty);
        return {pe, trn, bl, rdy, st};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input string name, input logic req, input logic [PB-1:0] bri,
                        input logic vs, input logic [2:0] st, input int duty);
        logic [6:0] exp;
        pwr_on_req = req;
        brightness = bri;
        vsync_in   = vs;
        sb_q.push_back(expect_out(st, duty, (edge_cnt + 1) % PER));
        @(posedge clk_in);
        edge_cnt++;
        #1;
        if (lcd_bl_pwm) bl_hi++;
        exp = sb_q.pop_front();
        check(name, 32'(dut_out), 32'(exp));
    endtask

    task automatic run(input string name, input int n, input logic req, input logic [PB-1:0] bri,
                       input logic vs, input logic [2:0] st, input int duty);
        for (int k = 0; k < n; k++) step(name, req, bri, vs, st, duty);
    endtask

    initial begin
        vecs[0]  = mk(1,  1'b0, 4'd8,  1'b1, 3'd0, 0, -1);
        vecs[1]  = mk(1,  1'b1, 4'd8,  1'b1, 3'd1, 0, -1);
        vecs[2]  = mk(7,  1'b1, 4'd8,  1'b1, 3'd1, 0, -1);
        vecs[3]  = mk(1,  1'b1, 4'd8,  1'b1, 3'd2, 0, -1);
        vecs[4]  = mk(5,  1'b1, 4'd8,  1'b0, 3'd2, 0, -1);
        vecs[5]  = mk(4,  1'b1, 4'd8,  1'b1, 3'd2, 0, -1);
        vecs[6]  = mk(5,  1'b1, 4'd8,  1'b0, 3'd2, 0, -1);
        vecs[7]  = mk(1,  1'b1, 4'd8,  1'b1, 3'd3, 8, -1);
        vecs[8]  = mk(3,  1'b1, 4'd8,  1'b1, 3'd3, 8, -1);
        vecs[9]  = mk(30, 1'b1, 4'd8,  1'b0, 3'd3, 8, 16);
        vecs[10] = mk(10, 1'b1, 4'd15, 1'b0, 3'd3, 8, -1);
        vecs[11] = mk(1,  1'b1, 4'd15, 1'b1, 3'd3, 15, -1);
        vecs[12] = mk(3,  1'b1, 4'd15, 1'b1, 3'd3, 15, -1);
        vecs[13] = mk(20, 1'b1, 4'd15, 1'b0, 3'd3, 15, 20);
        vecs[14] = mk(5,  1'b1, 4'd0,  1'b0, 3'd3, 15, -1);
        vecs[15] = mk(1,  1'b1, 4'd0,  1'b1, 3'd3, 0, -1);
        vecs[16] = mk(20, 1'b1, 4'd0,  1'b0, 3'd3, 0, 0);
        vecs[17] = mk(1,  1'b0, 4'd8,  1'b0, 3'd4, 0, -1);
        vecs[18] = mk(10, 1'b0, 4'd8,  1'b0, 3'd4, 0, -1);
        vecs[19] = mk(1,  1'b0, 4'd8,  1'b1, 3'd5, 0, -1);
        vecs[20] = mk(7,  1'b0, 4'd8,  1'b1, 3'd5, 0, -1);
        vecs[21] = mk(1,  1'b0, 4'd8,  1'b1, 3'd0, 0, -1);
        vecs[22] = mk(3,  1'b0, 4'd8,  1'b1, 3'd0, 0, -1);

        repeat (2) @(posedge clk_in);
        #1;
        check("reset_vals", 32'(dut_out), 32'd0);
        sys_rst  = 1'b0;
        edge_cnt = 0;

        // Power-up, brightness changes at frame edges, ordered power-down
        for (int i = 0; i < NV; i++) begin
            bl_hi = 0;
            run($sformatf("vec%0d", i), vecs[i].n, vecs[i].req, vecs[i].bri, vecs[i].vs,
                vecs[i].st, vecs[i].duty);
            if (vecs[i].hi >= 0)
                check($sformatf("pwm_hi_vec%0d", i), 32'(bl_hi), 32'(vecs[i].hi));
        end

        // Abort during PANEL_UP
        run("abort_up",   1, 1'b1, 4'd8, 1'b1, 3'd1, 0);
        run("abort_up",   2, 1'b1, 4'd8, 1'b1, 3'd1, 0);
        run("abort_drop", 1, 1'b0, 4'd8, 1'b1, 3'd5, 0);
        run("abort_down", 7, 1'b0, 4'd8, 1'b1, 3'd5, 0);
        run("abort_off",  2, 1'b0, 4'd8, 1'b1, 3'd0, 0);

        // Re-request during SCAN_DOWN is ignored until OFF has been held a cycle
        run("rereq_up",    8, 1'b1, 4'd5, 1'b1, 3'd1, 0);
        run("rereq_scan",  1, 1'b1, 4'd5, 1'b1, 3'd2, 0);
        run("rereq_scan",  3, 1'b1, 4'd5, 1'b0, 3'd2, 0);
        run("rereq_f1",    1, 1'b1, 4'd5, 1'b1, 3'd2, 0);
        run("rereq_scan",  2, 1'b1, 4'd5, 1'b0, 3'd2, 0);
        run("rereq_bl",    1, 1'b1, 4'd5, 1'b1, 3'd3, 5);
        run("rereq_bl",    5, 1'b1, 4'd5, 1'b1, 3'd3, 5);
        run("rereq_sdn",   1, 1'b0, 4'd5, 1'b0, 3'd4, 0);
        run("rereq_ign",   3, 1'b1, 4'd5, 1'b0, 3'd4, 0);
        run("rereq_pdn",   1, 1'b1, 4'd5, 1'b1, 3'd5, 0);
        run("rereq_pdn",   7, 1'b1, 4'd5, 1'b1, 3'd5, 0);
        run("rereq_off",   1, 1'b1, 4'd5, 1'b1, 3'd0, 0);
        run("rereq_again", 1, 1'b1, 4'd5, 1'b1, 3'd1, 0);

        // Asynchronous reset while in SCAN_UP
        run("rst_up",   7, 1'b1, 4'd5, 1'b1, 3'd1, 0);
        run("rst_scan", 1, 1'b1, 4'd5, 1'b1, 3'd2, 0);
        run("rst_scan", 2, 1'b1, 4'd5, 1'b0, 3'd2, 0);
        #2;
        sys_rst  = 1'b1;
        vsync_in = 1'b1;
        #1;
        check("async_rst", 32'(dut_out), 32'd0);
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_hold", 32'(dut_out), 32'd0);
        pwr_on_req = 1'b0;
        sys_rst    = 1'b0;
        edge_cnt   = 0;
        run("post_rst_off", 3, 1'b0, 4'd5, 1'b1, 3'd0, 0);
        run("post_rst_up",  1, 1'b1, 4'd5, 1'b1, 3'd1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_pwr_seq.md
# lcd_pwr_seq

Power-up/power-down sequencer and backlight dimmer for the RGB LCD panel. It sits between the system control logic and `lcd_ctrl`. It switches panel power, holds the timing generator in reset until the panel rails are stable, and waits a programmed number of frames before lighting the backlight. On power-down it runs the same steps in reverse. The backlight is PWM-dimmed, and the duty is updated only at frame boundaries so brightness changes never tear mid-frame.

## Interface
Parameters:
- `T_PWR_CYC`, 1000: clk_in cycles from panel power-on to timing-generator release; also the cycles from timing-generator reset to panel power-off.
- `FRAMES_ON`, 2: vsync rising edges counted after release before the backlight turns on (≥1).
- `FRAMES_OFF`, 2: vsync rising edges counted after the backlight turns off before the scan is stopped (≥1).
- `PWM_BITS`, 8: backlight PWM resolution.

Ports (one clock; reset is asynchronous and active-high):
- `clk_in`  in  1  pixel clock, same clock as `lcd_ctrl`.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `pwr_on_req`  in  1  level: 1 = panel on desired, 0 = panel off desired.
- `brightness`  in  PWM_BITS  requested backlight duty.
- `vsync_in`  in  1  `vsync` from `lcd_ctrl` (high during vertical blank lines).
- `panel_pwr_en`  out  1  panel supply enable.
- `timing_rst_n`  out  1  drives `lcd_ctrl.sys_rst_n`; 0 holds scan counters at zero.
- `lcd_bl_pwm`  out  1  backlight drive, 1 = lit.
- `ready`  out  1  1 only in BL_ON.
- `pwr_state`  out  3  current state encoding.

## Operation
- States and `pwr_state` encodings: OFF=0, PANEL_UP=1, SCAN_UP=2, BL_ON=3, SCAN_DOWN=4, PANEL_DOWN=5.
- OFF: all outputs 0. If `pwr_on_req`=1, load timer with `T_PWR_CYC`-1 and go to PANEL_UP.
- PANEL_UP: `panel_pwr_en`=1 and timer decrements.
  - Timer==0 with `pwr_on_req`=1: go to SCAN_UP and clear the frame counter.
  - `pwr_on_req`=0 (any cycle): abort. Load timer with `T_PWR_CYC`-1 and go to PANEL_DOWN.
- SCAN_UP: `timing_rst_n`=1. Count vsync rising edges (vsync_in=1 and the registered previous vsync_in=0).
  - When the count reaches `FRAMES_ON`: latch `duty`←`brightness` and go to BL_ON.
  - `pwr_on_req`=0: clear the frame counter and go to SCAN_DOWN.
- BL_ON: backlight PWM active.
  - On each vsync rising edge, `duty`←`brightness`.
  - `pwr_on_req`=0: clear the frame counter and go to SCAN_DOWN. `lcd_bl_pwm` is 0 from the next cycle.
- SCAN_DOWN: scan keeps running and the backlight is off. After `FRAMES_OFF` vsync rising edges, load timer with `T_PWR_CYC`-1 and go to PANEL_DOWN.
- PANEL_DOWN: `timing_rst_n`=0 and `panel_pwr_en`=1. When timer==0, go to OFF.
- `pwr_on_req` changes in SCAN_DOWN or PANEL_DOWN are ignored; the down sequence always completes. OFF lasts at least 1 cycle before a new power-up.
- PWM:
  - A free-running counter `cnt_pwm` counts 0 … 2^PWM_BITS−2, then wraps to 0 (period 2^PWM_BITS−1 cycles).
  - `lcd_bl_pwm` = (state==BL_ON) && (`cnt_pwm` < `duty`).
  - duty=0 gives constant 0; duty=2^PWM_BITS−1 gives constant 1.
- Widths:
  - Timer: clog2(`T_PWR_CYC`) bits.
  - Frame counter: wide enough for max(`FRAMES_ON`, `FRAMES_OFF`).
  - The frame counter saturates, never wraps.
- Edge detection: the previous-vsync register is forced to 1 while `timing_rst_n`=0. Because `lcd_ctrl` outputs vsync=1 in reset, releasing reset never produces a spurious edge.

## Timing
- All outputs are registered.
- Reset values: `panel_pwr_en`=0, `timing_rst_n`=0, `lcd_bl_pwm`=0, `ready`=0, `pwr_state`=0. Internal `duty`, timer, frame counter and `cnt_pwm` reset to 0; the previous-vsync register resets to 1.
- `pwr_on_req` rises at cycle 0:
  - `panel_pwr_en`=1 at cycle 1.
  - `timing_rst_n`=1 at cycle 1+`T_PWR_CYC`.
- The backlight-enable decision registers on the cycle after the `FRAMES_ON`-th vsync rising edge. `ready` rises the same cycle.
- `pwr_on_req` falls in BL_ON: `lcd_bl_pwm`=0 and `ready`=0 on the next edge.
- PANEL_DOWN entry to `panel_pwr_en`=0: exactly `T_PWR_CYC` cycles.
- A `brightness` change mid-frame takes effect only after the next vsync rising edge (+1 cycle).
- Asserting `sys_rst` in any state forces the reset values immediately, including mid-sequence; the panel drops power without the ordered shutdown.

## Test plan
Tests use T_PWR_CYC=8, FRAMES_ON=2, FRAMES_OFF=1, PWM_BITS=4, driven by a real `lcd_ctrl`.
- Full power-up with brightness=8: `panel_pwr_en`↑ at cycle 1, `timing_rst_n`↑ at cycle 9, `ready`↑ one cycle after the 2nd vsync rise, PWM high for 8 of every 15 cycles.
- Brightness 8→15 mid-frame: duty stays 8 until the next vsync rise, then `lcd_bl_pwm` stays constantly 1; brightness=0 gives constant 0.
- Drop `pwr_on_req` in BL_ON: BL=0 next cycle, one vsync rise later `timing_rst_n`=0, 8 cycles later `panel_pwr_en`=0, `pwr_state`=0.
- Drop `pwr_on_req` at cycle 4 of PANEL_UP: state goes to 5, `timing_rst_n` never rises, OFF after 8 cycles.
- Raise `pwr_on_req` again during SCAN_DOWN: the down sequence completes, OFF is held for ≥1 cycle, then PANEL_UP starts.
- Assert `sys_rst` in SCAN_UP: all outputs 0 asynchronously; after release the state stays OFF until `pwr_on_req` is sampled high.
